// File: rtl/histogram_reader.sv
// rtl/histogram_reader.sv - histogram RAM readout engine with optional clear-on-read
//
// Purpose: on START, sweeps bins 0..MAX_NUMBER of the shared single-port
// histogram RAM. Each {bin, count} pair goes out over a valid/ready handshake.
// When CLEAR was set at START, each bin is zeroed as its beat is accepted.
// Peak bin/count and the total of all counts are accumulated during the sweep
// and held until the next accepted START.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   START, CLEAR              sweep request, clear-on-read select (sampled in IDLE)
//   BUSY, DONE                sweep in progress, one-cycle completion pulse
//   adr_rd                    RAM address (read and clear-write)
//   mem_q                     RAM read data, one cycle after address
//   mem_wr_en, mem_wr_data    RAM clear strobe and data (always zero)
//   bin_out, cnt_out          current beat: bin index and its count
//   valid_out, ready_in       beat handshake
//   peak_bin, peak_cnt, total sweep results
module histogram_reader #(
  parameter int MAX_NUMBER = 127,
  parameter int SIZE       = 7,
  localparam int AW        = $clog2(MAX_NUMBER),
  localparam int TW        = SIZE + AW + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            CLEAR,
  output logic            BUSY,
  output logic            DONE,
  output logic [AW-1:0]   adr_rd,
  input  logic [SIZE-1:0] mem_q,
  output logic            mem_wr_en,
  output logic [SIZE-1:0] mem_wr_data,
  output logic [AW-1:0]   bin_out,
  output logic [SIZE-1:0] cnt_out,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [AW-1:0]   peak_bin,
  output logic [SIZE-1:0] peak_cnt,
  output logic [TW-1:0]   total
);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, FIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(MAX_NUMBER);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr_q, clr_d;
  logic [AW-1:0]   bin_q, bin_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   peak_bin_q, peak_bin_d;
  logic [SIZE-1:0] peak_cnt_q, peak_cnt_d;
  logic [TW-1:0]   total_q, total_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_q      <= 1'b0;
      bin_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      peak_bin_q <= '0;
      peak_cnt_q <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_q      <= clr_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      peak_bin_q <= peak_bin_d;
      peak_cnt_q <= peak_cnt_d;
      total_q    <= total_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_d      = clr_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    peak_bin_d = peak_bin_q;
    peak_cnt_d = peak_cnt_q;
    total_d    = total_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          clr_d      = CLEAR;
          idx_d      = '0;
          peak_bin_d = '0;
          peak_cnt_d = '0;
          total_d    = '0;
          state_d    = ADDR;
        end
      end
      // RAM samples adr_rd at the edge leaving ADDR; data is on mem_q in CAPT.
      ADDR: state_d = CAPT;
      CAPT: begin
        cnt_d   = mem_q;
        bin_d   = idx_q;
        valid_d = 1'b1;
        total_d = total_q + TW'(mem_q);
        // Strict compare: on ties the earlier (lower) bin wins.
        if (mem_q > peak_cnt_q) begin
          peak_cnt_d = mem_q;
          peak_bin_d = idx_q;
        end
        state_d = SEND;
      end
      SEND: begin
        if (ready_in) begin
          valid_d = 1'b0;
          if (idx_q == LAST) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ADDR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BUSY        = (state_q != IDLE);
  assign DONE        = (state_q == FIN);
  assign adr_rd      = idx_q;
  // The clear write lands on idx at the accept edge, so each bin is written once.
  assign mem_wr_en   = (state_q == SEND) & ready_in & clr_q;
  assign mem_wr_data = '0;
  assign bin_out     = bin_q;
  assign cnt_out     = cnt_q;
  assign valid_out   = valid_q;
  assign peak_bin    = peak_bin_q;
  assign peak_cnt    = peak_cnt_q;
  assign total       = total_q;

endmodule

// File: tb/tb_histogram_reader.sv
// tb/tb_histogram_reader.sv - self-checking bench for histogram_reader
module tb_histogram_reader;
  localparam int N   = 7;
  localparam int S   = 7;
  localparam int AW  = 3;
  localparam int NF  = 127;
  localparam int AWF = 7;

  int checks = 0;
  int errors = 0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b1;

  logic            START = 1'b0, CLEAR = 1'b0, ready_in = 1'b1;
  logic            BUSY, DONE, mem_wr_en, valid_out;
  logic [AW-1:0]   adr_rd, bin_out, peak_bin;
  logic [S-1:0]    mem_q, mem_wr_data, cnt_out, peak_cnt;
  logic [S+AW:0]   total;

  logic            START2 = 1'b0, ready2 = 1'b1;
  logic            BUSY2, DONE2, wr2, valid2;
  logic [AWF-1:0]  adr2, bin2, pbin2;
  logic [S-1:0]    mem_q2, wdat2, cnt2, pcnt2;
  logic [S+AWF:0]  total2;

  histogram_reader #(.MAX_NUMBER(N), .SIZE(S)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CLEAR(CLEAR), .BUSY(BUSY), .DONE(DONE),
    .adr_rd(adr_rd), .mem_q(mem_q), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .bin_out(bin_out), .cnt_out(cnt_out), .valid_out(valid_out), .ready_in(ready_in),
    .peak_bin(peak_bin), .peak_cnt(peak_cnt), .total(total));

  histogram_reader #(.MAX_NUMBER(NF), .SIZE(S)) dut_full (
    .CLK(CLK), .RST(RST), .START(START2), .CLEAR(1'b0), .BUSY(BUSY2), .DONE(DONE2),
    .adr_rd(adr2), .mem_q(mem_q2), .mem_wr_en(wr2), .mem_wr_data(wdat2),
    .bin_out(bin2), .cnt_out(cnt2), .valid_out(valid2), .ready_in(ready2),
    .peak_bin(pbin2), .peak_cnt(pcnt2), .total(total2));

  // Synchronous single-port RAM models with a preload port owned by the bench.
  logic [S-1:0]  ram [0:N];
  logic [S-1:0]  pre [0:N];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_adr = '0;
  logic [S-1:0]  pre_dat = '0;
  always @(posedge CLK) begin
    if (pre_we) ram[pre_adr] <= pre_dat;
    else if (mem_wr_en) ram[adr_rd] <= mem_wr_data;
    mem_q <= ram[adr_rd];
  end

  logic [S-1:0] ram2 [0:NF];
  logic         fill2 = 1'b0;
  always @(posedge CLK) begin
    if (fill2) begin
      for (int i = 0; i <= NF; i++) ram2[i] <= 7'd127;
    end else if (wr2) ram2[adr2] <= wdat2;
    mem_q2 <= ram2[adr2];
  end

  task automatic load_ram();
    for (int i = 0; i <= N; i++) begin
      @(negedge CLK);
      pre_we = 1'b1; pre_adr = AW'(i); pre_dat = pre[i];
    end
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  // One sweep of the 8-bin DUT, checked against a model built from the RAM
  // contents captured before START. stall_bin/stall_len force backpressure,
  // rnd_ready randomises ready_in, poke pulses START while busy, rst_bin >= 0
  // asserts RST while that bin's beat is waiting.
  task automatic sweep(input bit clr, input int stall_bin, input int stall_len,
                       input bit rnd_ready, input bit poke, input int rst_bin);
    int snap [0:N];
    int exp_pk, exp_pb, exp_tot, nbeats, stalls, done_edge, stalled, exp_done;
    logic [AW-1:0] hb;
    logic [S-1:0]  hc;
    bit holding, aborted;
    exp_pk = 0; exp_tot = 0;
    for (int i = 0; i <= N; i++) begin
      snap[i] = int'(ram[i]);
      exp_tot += snap[i];
      if (snap[i] > exp_pk) exp_pk = snap[i];
    end
    exp_pb = 0;
    for (int i = N; i >= 0; i--) if (snap[i] == exp_pk) exp_pb = i;

    @(negedge CLK);
    START = 1'b1; CLEAR = clr; ready_in = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0; CLEAR = ~clr;
    nbeats = 0; stalls = 0; done_edge = -1; stalled = 0; holding = 0; aborted = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_start: got %b want 1", BUSY); end
      end
      if (k == 2) begin
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL first_valid_latency: got %b want 1", valid_out); end
      end
      if (holding) begin
        checks++;
        if (valid_out !== 1'b1 || bin_out !== hb || cnt_out !== hc) begin
          errors++;
          $display("FAIL stall_stable: got v=%b bin=%0d cnt=%0d want v=1 bin=%0d cnt=%0d",
                   valid_out, bin_out, cnt_out, hb, hc);
        end
      end
      if (DONE === 1'b1) begin done_edge = k + 1; break; end
      if (rst_bin >= 0 && valid_out === 1'b1 && int'(bin_out) == rst_bin) begin
        ready_in = 1'b0;
        RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, DONE, adr_rd, mem_wr_en, bin_out, cnt_out, valid_out, peak_bin, peak_cnt, total} !== '0) begin
          errors++;
          $display("FAIL reset_mid_outputs: got busy=%b done=%b adr=%0d wr=%b bin=%0d cnt=%0d v=%b pb=%0d pc=%0d tot=%0d want all 0",
                   BUSY, DONE, adr_rd, mem_wr_en, bin_out, cnt_out, valid_out, peak_bin, peak_cnt, total);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        aborted = 1;
        break;
      end
      ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_out === 1'b1 && int'(bin_out) == stall_bin && stalled < stall_len) begin
        ready_in = 1'b0; stalled++;
      end
      START = poke && (k == 5 || k == 10);
      #1;
      checks++;
      if (mem_wr_en !== (valid_out && ready_in && clr)) begin
        errors++;
        $display("FAIL wr_en: got %b want %b (k=%0d)", mem_wr_en, valid_out && ready_in && clr, k);
      end
      if (valid_out === 1'b1) begin
        if (ready_in) begin
          holding = 0;
          checks++;
          if (nbeats > N || int'(bin_out) != nbeats || int'(cnt_out) != snap[nbeats]) begin
            errors++;
            $display("FAIL beat: got bin=%0d cnt=%0d want bin=%0d cnt=%0d", bin_out, cnt_out,
                     nbeats, (nbeats <= N) ? snap[nbeats] : -1);
          end
          if (mem_wr_en) begin
            checks++;
            if (adr_rd !== bin_out || mem_wr_data !== '0) begin
              errors++;
              $display("FAIL clear_write: got adr=%0d data=%0d want adr=%0d data=0", adr_rd, mem_wr_data, bin_out);
            end
          end
          nbeats++;
        end else begin
          stalls++; holding = 1; hb = bin_out; hc = cnt_out;
        end
      end
    end
    START = 1'b0; ready_in = 1'b1;

    if (aborted) begin
      for (int i = 0; i <= N; i++) begin
        checks++;
        if (int'(ram[i]) != ((clr && i < rst_bin) ? 0 : snap[i])) begin
          errors++;
          $display("FAIL ram_after_reset[%0d]: got %0d want %0d", i, ram[i], (clr && i < rst_bin) ? 0 : snap[i]);
        end
      end
      return;
    end

    exp_done = 3 * (N + 1) + 1 + stalls;
    checks++;
    if (nbeats != N + 1) begin errors++; $display("FAIL beat_count: got %0d want %0d", nbeats, N + 1); end
    checks++;
    if (done_edge != exp_done) begin errors++; $display("FAIL done_cycle: got %0d want %0d", done_edge, exp_done); end
    if (!rnd_ready && stall_bin >= 0) begin
      checks++;
      if (stalls != stall_len) begin errors++; $display("FAIL stall_count: got %0d want %0d", stalls, stall_len); end
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL after_done: got done=%b busy=%b want 0 0", DONE, BUSY);
    end
    checks++;
    if (int'(peak_bin) != exp_pb || int'(peak_cnt) != exp_pk || int'(total) != exp_tot) begin
      errors++;
      $display("FAIL results: got pb=%0d pc=%0d tot=%0d want pb=%0d pc=%0d tot=%0d",
               peak_bin, peak_cnt, total, exp_pb, exp_pk, exp_tot);
    end
    for (int i = 0; i <= N; i++) begin
      checks++;
      if (int'(ram[i]) != (clr ? 0 : snap[i])) begin
        errors++; $display("FAIL ram_after[%0d]: got %0d want %0d", i, ram[i], clr ? 0 : snap[i]);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, adr_rd, mem_wr_en, bin_out, cnt_out, valid_out, peak_bin, peak_cnt, total} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero, want all 0");
    end
    checks++;
    if ({BUSY2, DONE2, wr2, valid2, pbin2, pcnt2, total2} !== '0) begin
      errors++; $display("FAIL reset_outputs_full: got nonzero, want all 0");
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    pre = '{7'd0, 7'd3, 7'd0, 7'd9, 7'd9, 7'd1, 7'd0, 7'd2};
    load_ram();
    sweep(1'b0, -1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (peak_bin !== 3'd3 || peak_cnt !== 7'd9 || total !== 11'd24) begin
      errors++; $display("FAIL basic_results: got pb=%0d pc=%0d tot=%0d want 3 9 24", peak_bin, peak_cnt, total);
    end
  endtask

  task automatic test_clear();
    load_ram();
    sweep(1'b1, -1, 0, 1'b0, 1'b0, -1);
    sweep(1'b0, -1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (total !== '0 || peak_bin !== '0 || peak_cnt !== '0) begin
      errors++; $display("FAIL clear_resweep: got tot=%0d pb=%0d pc=%0d want 0 0 0", total, peak_bin, peak_cnt);
    end
  endtask

  task automatic test_backpressure();
    load_ram();
    sweep(1'b1, 2, 4, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_busy();
    load_ram();
    sweep(1'b0, -1, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    load_ram();
    sweep(1'b1, -1, 0, 1'b0, 1'b0, 4);
    sweep(1'b0, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i <= N; i++) pre[i] = 7'($urandom_range(0, 127));
      load_ram();
      sweep(1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0, -1);
    end
  endtask

  task automatic test_full_scale();
    int done_edge;
    @(negedge CLK); fill2 = 1'b1;
    @(negedge CLK); fill2 = 1'b0; START2 = 1'b1; ready2 = 1'b1;
    @(posedge CLK);
    #1 START2 = 1'b0;
    done_edge = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      if (DONE2 === 1'b1) begin done_edge = k + 1; break; end
    end
    checks++;
    if (done_edge != 3 * (NF + 1) + 1) begin
      errors++; $display("FAIL full_done_cycle: got %0d want %0d", done_edge, 3 * (NF + 1) + 1);
    end
    checks++;
    if (int'(total2) != (NF + 1) * 127 || pbin2 !== '0 || pcnt2 !== 7'd127) begin
      errors++;
      $display("FAIL full_results: got tot=%0d pb=%0d pc=%0d want %0d 0 127", total2, pbin2, pcnt2, (NF + 1) * 127);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_full_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_reader.md
# histogram_reader

Readout engine for the histogram memory: on a start request it sweeps every bin address of the same single-port histogram RAM that the histogram unit fills. It streams each `{bin, count}` pair out over a valid/ready handshake and optionally clears each bin after it is read. While sweeping, it also computes the peak bin and the total sample count. It sits between the histogram RAM and any downstream consumer (UART/display formatter), and owns the RAM port while `BUSY` is high.

## Interface
- `MAX_NUMBER`, default 127: highest bin index; bins are 0..MAX_NUMBER; `AW = $clog2(MAX_NUMBER)`.
- `SIZE`, default 7: width of one bin count.
- `CLK  in  1`: single clock, all logic on posedge.
- `RST  in  1`: asynchronous, active-high reset.
- `START  in  1`: begin a sweep; sampled only in IDLE.
- `CLEAR  in  1`: sampled with START; 1 means zero each bin after it is read.
- `BUSY  out  1`: high from the cycle after START acceptance through FIN.
- `DONE  out  1`: one-cycle pulse in FIN.
- `adr_rd  out  AW`: RAM address, equal to the internal index `idx`.
- `mem_q  in  SIZE`: RAM read data, valid one cycle after the address.
- `mem_wr_en  out  1`: RAM write strobe, used for clear only.
- `mem_wr_data  out  SIZE`: always 0.
- `bin_out  out  AW`: bin index of the current beat.
- `cnt_out  out  SIZE`: count of the current beat.
- `valid_out  out  1`: beat valid.
- `ready_in  in  1`: consumer accepts the beat.
- `peak_bin  out  AW`: bin with the largest count.
- `peak_cnt  out  SIZE`: largest count.
- `total  out  SIZE+AW+1`: sum of all counts read.

## Operation
- **States:** IDLE, ADDR, CAPT, SEND, FIN.
- **IDLE:** on `START`, latch `CLEAR` into `clr_q`, set `idx<=0`, `peak_bin<=0`, `peak_cnt<=0`, `total<=0`, then go to ADDR.
- **ADDR:** `adr_rd=idx` is presented and the RAM samples it at this edge. Go to CAPT.
- **CAPT:**
  - Set `cnt_out<=mem_q`, `bin_out<=idx`, `valid_out<=1`.
  - Set `total<=total+mem_q`, zero-extended.
  - If `mem_q>peak_cnt` (strictly greater), set `peak_cnt<=mem_q` and `peak_bin<=idx`. Ties therefore keep the lowest bin.
  - Go to SEND.
- **SEND:**
  - `valid_out` is held with `bin_out`/`cnt_out` stable until `ready_in=1`.
  - On the accept edge: `valid_out<=0`.
  - `mem_wr_en = (state==SEND) & ready_in & clr_q`, combinational. The write address is `idx` and the data is 0.
  - Then, if `idx==MAX_NUMBER`, go to FIN; else `idx<=idx+1` and go to ADDR.
- **FIN:** `DONE=1` for one cycle, then IDLE.
- **Simultaneous events and ignored inputs:**
  - `START` outside IDLE is ignored.
  - `CLEAR` outside START acceptance is ignored.
  - `ready_in` outside SEND is ignored.
- **Arithmetic:**
  - `total` cannot overflow: the worst case is (MAX_NUMBER+1)·(2^SIZE−1).
  - `idx` never wraps; it terminates at MAX_NUMBER.
- **Result hold:** `peak_bin`, `peak_cnt` and `total` hold their values after DONE until the next accepted START.

## Timing
- **Reset (async):** state=IDLE; every output is 0, including `adr_rd`, `mem_wr_en`, `valid_out`, `DONE`, `BUSY`, `peak_*` and `total`. No RAM write occurs during or after reset. Reset mid-sweep abandons the sweep; bins not yet cleared keep their values.
- **Latency:** `valid_out` rises 2 cycles after the START edge, i.e. in the cycle following CAPT.
- **Per-bin cost:** 3 cycles per bin with `ready_in` held high.
- **DONE:** asserted 3·(MAX_NUMBER+1)+1 cycles after the START edge when `ready_in` is held high. Each cycle of backpressure adds exactly one cycle.
- **BUSY:** is 1 in ADDR/CAPT/SEND/FIN.
- **Clear writes:** `mem_wr_en` is never high for more than one cycle per bin.

## Test plan
- **Basic sweep:** MAX_NUMBER=7, RAM preloaded {0,3,0,9,9,1,0,2}, START with CLEAR=0, `ready_in`=1.
  - Expect 8 beats with `bin_out` 0..7 and counts as loaded.
  - Expect `peak_bin`=3, `peak_cnt`=9 (tie at bin 4 rejected), `total`=24.
  - Expect `DONE` exactly at cycle 25 after START.
  - Expect the RAM unchanged.
- **Clear-on-read:** same preload, CLEAR=1.
  - Expect 8 `mem_wr_en` pulses at addresses 0..7 with data 0.
  - A second sweep returns all-zero counts, `total`=0, `peak_bin`=0.
- **Backpressure:** `ready_in` low for 4 cycles on bin 2.
  - Expect `valid_out`/`bin_out`/`cnt_out` stable across the stall.
  - Expect no `mem_wr_en` until accept, and `DONE` delayed by exactly 4 cycles.
- **Full-scale:** MAX_NUMBER=127, SIZE=7, all bins=127.
  - Expect `total`=16256, `peak_bin`=0, `peak_cnt`=127, `DONE` at cycle 385.
- **START during BUSY and mid-sweep reset:**
  - START pulsed while BUSY is ignored: the beat count stays 8.
  - RST asserted during bin 4 SEND with CLEAR=1 forces all outputs to 0 immediately. Bins 0..3 read 0 and bins 4..7 keep their preload on a re-sweep.
